// File: rtl/k4red_unscale.sv
// k4red_unscale: removes the k^2 factor left by the K^2-RED/K^4-RED reducer.
// For an NTT prime Q = k*2^m + 1, k^-2 = 2^(2m) mod Q, so the block computes
// Y = X * 2^(2m) mod Q with 2m modular doublings, one per RUN cycle.
// Valid/ready stream on both sides; one word in flight at a time.
//
// Build option K4RED_UNSCALE_DUAL_STEP_EN: two cascaded doublings per RUN
// cycle, halving the RUN length to m cycles with identical results.
module k4red_unscale #(
  parameter int W  = 32,
  parameter int MW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  X,
  input  logic [W-1:0]  Q,
  input  logic [MW-1:0] m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Y,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  x_r;    // running residue, kept below q_r
  logic [W-1:0]  q_r;    // modulus captured at accept
  logic [MW:0]   cnt;    // remaining RUN cycles

  logic          accept;
  logic [W-1:0]  x_pre;
  logic [MW:0]   cnt_load;
  logic [W-1:0]  x_step;
  logic [W-1:0]  x_next;

  // One modular doubling: 2a mod b for a < b. The doubled value needs W+1
  // bits; when it is >= b the difference is below b, so the low W bits of
  // the W-bit subtraction are exact.
  function automatic logic [W-1:0] mod_dbl(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] d;
    t = {a, 1'b0};
    d = t[W-1:0] - b;
    mod_dbl = (t >= {1'b0, b}) ? d : t[W-1:0];
  endfunction

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Inputs arrive in [0, 2Q), so a single conditional subtract lands in [0, Q).
  assign x_pre = (X >= Q) ? X - Q : X;

`ifdef K4RED_UNSCALE_DUAL_STEP_EN
  assign cnt_load = {1'b0, m};
`else
  assign cnt_load = {m, 1'b0};
`endif

  // Datapath for one RUN cycle: one or two cascaded doublings.
  always_comb begin
    // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
    x_step = mod_dbl(x_r, q_r);
`ifdef K4RED_UNSCALE_DUAL_STEP_EN
    x_next = mod_dbl(x_step, q_r);
`else
    x_next = x_step;
`endif
  end

  // Control FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      x_r       <= '0;
      q_r       <= '0;
      cnt       <= '0;
      Y         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_r  <= Q;
            x_r  <= x_pre;
            cnt  <= cnt_load;
            busy <= 1'b1;
            if (m == '0) begin
              Y         <= x_pre;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          x_r <= x_next;
          cnt <= cnt - 1'b1;
          if (cnt == {{MW{1'b0}}, 1'b1}) begin
            Y         <= x_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k4red_unscale.sv
// Testbench for k4red_unscale: a cycle-level behavioural model (result from
// modular exponentiation, timing from a step countdown) is compared against
// the DUT every cycle, plus hand-computed literal results.
module tb_k4red_unscale;

  localparam int W  = 32;
  localparam int MW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  X;
  logic [W-1:0]  Q;
  logic [MW-1:0] m;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Y;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  k4red_unscale #(.W(W), .MW(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Q         (Q),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // X * 2^(2m) mod Q by square-and-multiply in 64-bit arithmetic.
  function automatic logic [W-1:0] golden(input logic [W-1:0] xv, input logic [W-1:0] qv,
                                          input int mm);
    longint unsigned q, r, p, b;
    int e;
    q = longint'(qv);
    r = longint'(xv) % q;
    p = 1;
    b = 2 % q;
    e = 2 * mm;
    while (e > 0) begin
      if (e % 2 == 1) p = (p * b) % q;
      b = (b * b) % q;
      e = e / 2;
    end
    golden = W'((r * p) % q);
  endfunction

  function automatic int steps_of(input int mm);
`ifdef K4RED_UNSCALE_DUAL_STEP_EN
    steps_of = mm;
`else
    steps_of = 2 * mm;
`endif
  endfunction

  // Behavioural model: busy/done flags and a countdown of remaining steps.
  logic         m_busy = 1'b0;
  logic         m_ov   = 1'b0;
  logic [W-1:0] m_y    = '0;
  logic [W-1:0] m_exp  = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ov   <= 1'b0;
      m_y    <= '0;
      m_left <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_exp  <= golden(X, Q, int'(m));
        if (m == '0) begin
          m_ov <= 1'b1;
          m_y  <= golden(X, Q, 0);
        end else begin
          m_left <= steps_of(int'(m));
        end
      end
    end else if (!m_ov) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_ov <= 1'b1;
        m_y  <= m_exp;
      end
    end else if (out_ready) begin
      m_ov   <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, sampled away from the clock edge.
  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      #1;
      check("in_ready", in_ready, (!m_busy && !rst));
      check("busy", busy, m_busy);
      check("out_valid", out_valid, m_ov);
      if (m_ov) check("Y", Y, m_y);
    end
  end

  // One transaction: offer a word, wait for the result, optionally hold
  // backpressure, complete the output handshake.
  task automatic do_txn(input logic [W-1:0] xv, input logic [W-1:0] qv, input logic [MW-1:0] mv,
                        input int hold, input bit noise,
                        output logic [W-1:0] y_got, output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    X = xv;
    Q = qv;
    m = mv;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);                 // accept edge
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    X = $urandom;
    Q = $urandom;
    m = MW'($urandom);
    guard = 0;
    while (!out_valid && guard < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (noise) in_valid = 1'($urandom_range(0, 1));
      guard++;
    end
    if (guard >= 400) check("out_valid_timeout", out_valid, 1);
    check("latency", lat, steps_of(int'(mv)) + 1);
    y_got = Y;
    for (int i = 0; i < hold; i++) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("hold_Y", Y, y_got);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);                 // output handshake
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] y;
    int lat;
    longint unsigned qq, xx;
    int mm;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    X = '0;
    Q = '0;
    m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_Y", Y, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    started = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Directed cases with hand-computed results.
    do_txn(32'd1, 32'd7681, 6'd9, 0, 1'b0, y, lat);
    check("q7681_x1", y, 990);
`ifdef K4RED_UNSCALE_DUAL_STEP_EN
    check("q7681_x1_lat", lat, 10);
`else
    check("q7681_x1_lat", lat, 19);
`endif
    do_txn(32'd225, 32'd7681, 6'd9, 0, 1'b0, y, lat);
    check("q7681_x225", y, 1);
    do_txn(32'd9, 32'd12289, 6'd12, 0, 1'b0, y, lat);
    check("q12289_x9", y, 1);
    do_txn(32'd12289, 32'd12289, 6'd12, 0, 1'b0, y, lat);
    check("q12289_xeqq", y, 0);
    do_txn(32'd12290, 32'd12289, 6'd12, 0, 1'b0, y, lat);
    check("q12289_x12290", y, 2731);
    do_txn(32'd3, 32'd5, 6'd0, 2, 1'b1, y, lat);
    check("q5_m0", y, 3);
    check("q5_m0_lat", lat, 1);
    do_txn(32'd1, 32'd7681, 6'd9, 5, 1'b0, y, lat);
    check("q7681_backpressure", y, 990);

    // Reset asserted in the middle of RUN.
    @(negedge clk);
    in_valid = 1'b1;
    X = 32'd1;
    Q = 32'd7681;
    m = 6'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_Y", Y, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    do_txn(32'd225, 32'd7681, 6'd9, 0, 1'b0, y, lat);
    check("after_abort_x225", y, 1);

    // Randomized traffic over arbitrary odd moduli; the model supplies results.
    for (int i = 0; i < 150; i++) begin
      qq = longint'($urandom | 32'd1);
      if (qq < 3) qq = 3;
      xx = {$urandom, $urandom};
      xx = xx % (2 * qq);
      mm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 16));
      do_txn(W'(xx), W'(qq), MW'(mm), int'($urandom_range(0, 3)), 1'b1, y, lat);
      check("rand_Y", y, golden(W'(xx), W'(qq), mm));
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
